muldiv_sequencer: RTL and testbench

Controller that sequences the shared multiplier and divisor units of the multi-cycle CPU on behalf of the main control FSM.
- Accepts one mult/div request at a time and issues the one-cycle start pulse to the selected unit.
- Waits for that unit's completion flag, then drives the HI/LO source selects and write enables for one commit cycle.
- Reports done, divide-by-zero, and (optionally) timeout back to the main controller.
- Replaces the ad hoc mult/div wait states in the main control FSM.

---
 rtl/muldiv_defs.sv | 18 +
 rtl/muldiv_watchdog.sv | 31 +++
 rtl/muldiv_sequencer.sv | 117 +++++++++++
 tb/tb_muldiv_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_defs.sv
// Shared definitions for the mult/div sequencer: FSM state encodings,
// operation codes and default watchdog sizing.
package muldiv_defs;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_EXC    = 3'd5;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int CNT_W_DEF          = 7;

endpackage

// File: rtl/muldiv_watchdog.sv
// WAIT-state watchdog for the mult/div sequencer. Compiled only when
// MULDIV_TIMEOUT_EN is defined, since nothing else instantiates it.
`ifdef MULDIV_TIMEOUT_EN
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Counting stops at the terminal value; the sequencer leaves WAIT there.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/muldiv_sequencer.sv
// Sequences the shared multiplier/divisor for the main control FSM: start
// pulse, completion wait, HI/LO commit, done/exception reporting.
// Optional WAIT watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer
    import muldiv_defs::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic op_valid,
    input  logic op_sel,
    output logic op_ready,
    output logic busy,
    output logic mult_start,
    output logic div_start,
    input  logic mult_fim,
    input  logic div_fim,
    input  logic div_by_zero,
    output logic hi_sel,
    output logic lo_sel,
    output logic hi_write,
    output logic lo_write,
    output logic done,
    output logic exc_divzero,
    output logic exc_timeout
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_cfg
        $error("muldiv_sequencer: CNT_W too narrow for TIMEOUT_CYCLES");
    end

    logic [2:0] state;
    logic [2:0] state_next;
    logic       op;
    logic       unit_sel;
    logic       fim_sel;
    logic       div_abort;
    logic       timeout_hit;
    logic       exc_is_timeout;

    assign fim_sel   = (op == OP_DIV) ? div_fim : mult_fim;
    assign div_abort = (op == OP_DIV) && div_by_zero;

`ifdef MULDIV_TIMEOUT_EN
    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (state != S_WAIT),
        .enable  (state == S_WAIT),
        .expired (timeout_hit)
    );

    // Remembers which abort led into EXC so the right flag is pulsed there.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exc_is_timeout <= 1'b0;
        end else if (state_next == S_EXC) begin
            exc_is_timeout <= !div_abort;
        end
    end
`else
    assign timeout_hit    = 1'b0;
    assign exc_is_timeout = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (op_valid) state_next = S_START;
            S_START:  state_next = div_abort ? S_EXC : S_WAIT;
            S_WAIT: begin
                if (div_abort)        state_next = S_EXC;
                else if (fim_sel)     state_next = S_COMMIT;
                else if (timeout_hit) state_next = S_EXC;
            end
            S_COMMIT: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            S_EXC:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op       <= OP_MULT;
            unit_sel <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && op_valid) begin
                op       <= op_sel;
                unit_sel <= op_sel;
            end
        end
    end

    // Moore decode; HI/LO selects persist until the next accepted request.
    assign op_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign mult_start  = (state == S_START) && (op == OP_MULT);
    assign div_start   = (state == S_START) && (op == OP_DIV);
    assign hi_sel      = unit_sel;
    assign lo_sel      = unit_sel;
    assign hi_write    = (state == S_COMMIT);
    assign lo_write    = (state == S_COMMIT);
    assign done        = (state == S_DONE);
    assign exc_divzero = (state == S_EXC) && !exc_is_timeout;
    assign exc_timeout = (state == S_EXC) && exc_is_timeout;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a scoreboard of expected
// start/commit/done/exception events. Define MULDIV_TIMEOUT_EN for watchdog cases.
module tb_muldiv_sequencer;

`ifdef MULDIV_TIMEOUT_EN
    localparam int TO      = 8;
    localparam int MULT_K  = 6;
`else
    localparam int TO      = 64;
    localparam int MULT_K  = 34;
`endif

    localparam int K_DONE = 0;
    localparam int K_DZ   = 1;
    localparam int K_TO   = 2;

    logic clock, reset;
    logic op_valid, op_sel, op_ready, busy;
    logic mult_start, div_start, mult_fim, div_fim, div_by_zero;
    logic hi_sel, lo_sel, hi_write, lo_write, done, exc_divzero, exc_timeout;

    muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_sel      (op_sel),
        .op_ready    (op_ready),
        .busy        (busy),
        .mult_start  (mult_start),
        .div_start   (div_start),
        .mult_fim    (mult_fim),
        .div_fim     (div_fim),
        .div_by_zero (div_by_zero),
        .hi_sel      (hi_sel),
        .lo_sel      (lo_sel),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .done        (done),
        .exc_divzero (exc_divzero),
        .exc_timeout (exc_timeout)
    );

    typedef struct {
        int   kind;
        logic sel;
        int   start_cyc;
        int   write_cyc;
        int   end_cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   done_count = 0;
    bit   wrote      = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    // Issue a request; k is the cycle (1 = START) in which the deciding
    // condition (fim, div_by_zero or terminal count) is seen by the DUT.
    task automatic issue(input logic sel, input int kind, input int k);
        int   a;
        int   guard;
        exp_t e;
        guard = 0;
        while (op_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before_issue", op_ready, 1'b1);
        op_valid = 1'b1;
        op_sel   = sel;
        tick();
        op_valid = 1'b0;
        a = cyc;
        e.kind      = kind;
        e.sel       = sel;
        e.start_cyc = a;
        e.write_cyc = a + k;
        e.end_cyc   = (kind == K_DONE) ? a + k + 1 : a + k;
        sb.push_back(e);
    endtask

    // Scoreboard side: compare every DUT event against the oldest expectation.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (mult_start || div_start) begin
                check("start_has_entry", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    check("start_cycle", cyc, sb[0].start_cyc);
                    check("mult_start", mult_start, sb[0].sel == 1'b0);
                    check("div_start", div_start, sb[0].sel == 1'b1);
                end
            end
            if (hi_write || lo_write) begin
                check("write_has_entry", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    check("write_kind", K_DONE, sb[0].kind);
                    check("write_cycle", cyc, sb[0].write_cyc);
                    check("hi_write", hi_write, 1'b1);
                    check("lo_write", lo_write, 1'b1);
                    check("hi_sel", hi_sel, sb[0].sel);
                    check("lo_sel", lo_sel, sb[0].sel);
                    wrote = 1'b1;
                end
            end
            if (done) begin
                done_count++;
                check("done_has_entry", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    check("done_kind", K_DONE, sb[0].kind);
                    check("done_cycle", cyc, sb[0].end_cyc);
                    check("done_after_write", wrote, 1'b1);
                    void'(sb.pop_front());
                    wrote = 1'b0;
                end
            end
            if (exc_divzero || exc_timeout) begin
                check("exc_has_entry", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    check("exc_divzero", exc_divzero, sb[0].kind == K_DZ);
                    check("exc_timeout", exc_timeout, sb[0].kind == K_TO);
                    check("exc_cycle", cyc, sb[0].end_cyc);
                    check("exc_no_write", wrote, 1'b0);
                    void'(sb.pop_front());
                    wrote = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int saved_done;
        reset       = 1'b1;
        op_valid    = 1'b0;
        op_sel      = 1'b0;
        mult_fim    = 1'b0;
        div_fim     = 1'b0;
        div_by_zero = 1'b0;
        #1 reset = 1'b0;
        #3;
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_starts", {mult_start, div_start}, 2'b00);
        check("rst_writes", {hi_write, lo_write}, 2'b00);
        check("rst_sels", {hi_sel, lo_sel}, 2'b00);
        check("rst_flags", {done, exc_divzero, exc_timeout}, 3'b000);
        wait_cycles(2);
        reset = 1'b1;
        tick();

        // Multiply with completion in cycle MULT_K.
        issue(1'b0, K_DONE, MULT_K);
        wait_cycles(MULT_K - 1);
        mult_fim = 1'b1;
        tick();
        mult_fim = 1'b0;
        wait_cycles(2);
        check("mult_ready_after", op_ready, 1'b1);
        check("mult_busy_after", busy, 1'b0);

        // Divide-by-zero coinciding with div_fim in WAIT.
        issue(1'b1, K_DZ, 3);
        wait_cycles(2);
        div_by_zero = 1'b1;
        div_fim     = 1'b1;
        tick();
        div_by_zero = 1'b0;
        div_fim     = 1'b0;
        check("dz_no_write", {hi_write, lo_write}, 2'b00);
        tick();
        check("dz_ready_after", op_ready, 1'b1);

        // Divide with START-time fim, wrong-unit fim and a request while busy.
        issue(1'b1, K_DONE, 10);
        div_fim = 1'b1;
        tick();
        div_fim  = 1'b0;
        mult_fim = 1'b1;
        op_valid = 1'b1;
        op_sel   = 1'b0;
        tick();
        mult_fim = 1'b0;
        check("busy_ignores_req", op_ready, 1'b0);
        wait_cycles(3);
        op_valid = 1'b0;
        wait_cycles(4);
        div_fim = 1'b1;
        tick();
        div_fim = 1'b0;
        wait_cycles(2);
        check("div_ready_after", op_ready, 1'b1);
        check("hi_sel_held", hi_sel, 1'b1);
        check("lo_sel_held", lo_sel, 1'b1);

        // Divide-by-zero already flagged during START.
        issue(1'b1, K_DZ, 1);
        div_by_zero = 1'b1;
        tick();
        div_by_zero = 1'b0;
        tick();
        check("dz_start_ready", op_ready, 1'b1);

`ifdef MULDIV_TIMEOUT_EN
        // No fim: 8th WAIT cycle (cycle 9) expires, exc_timeout in cycle 10.
        issue(1'b0, K_TO, 9);
        wait_cycles(10);
        check("to_ready_after", op_ready, 1'b1);
        // fim on the terminal count wins over the timeout.
        issue(1'b0, K_DONE, 9);
        wait_cycles(8);
        mult_fim = 1'b1;
        tick();
        mult_fim = 1'b0;
        wait_cycles(2);
        check("to_fim_ready_after", op_ready, 1'b1);
`else
        // Without the watchdog, WAIT holds well past any timeout bound.
        issue(1'b0, K_DONE, 101);
        wait_cycles(100);
        check("long_wait_busy", busy, 1'b1);
        mult_fim = 1'b1;
        tick();
        mult_fim = 1'b0;
        wait_cycles(2);
        check("long_wait_ready", op_ready, 1'b1);
`endif

        // Asynchronous reset while a divide is in WAIT.
        issue(1'b1, K_DONE, 1000);
        wait_cycles(3);
        check("pre_reset_busy", busy, 1'b1);
        div_fim = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("async_op_ready", op_ready, 1'b1);
        check("async_busy", busy, 1'b0);
        check("async_starts", {mult_start, div_start}, 2'b00);
        check("async_writes", {hi_write, lo_write}, 2'b00);
        check("async_sels", {hi_sel, lo_sel}, 2'b00);
        check("async_flags", {done, exc_divzero, exc_timeout}, 3'b000);
        sb.delete();
        wrote = 1'b0;
        saved_done = done_count;
        tick();
        reset = 1'b1;
        check("post_reset_ready", op_ready, 1'b1);
        wait_cycles(6);
        div_fim = 1'b0;
        wait_cycles(2);
        check("abort_no_done", done_count, saved_done);
        check("abort_still_idle", op_ready, 1'b1);

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
